// File: rtl/cdp1861_pkg.sv
// cdp1861_pkg: shared constants and types for the Pixie video controller.
//   - default frame geometry (cycles per line, lines, visible window)
//   - CPU state codes as seen on SC, and the IO port number that
//     switches the display on (io_inp) and off (io_out)
//   - status_t: counter/flag snapshot exported on the debug port
package cdp1861_pkg;

    localparam int DEF_CYCLES_PER_LINE = 14;
    localparam int DEF_LINES           = 262;
    localparam int DEF_FIRST_LINE      = 80;
    localparam int DEF_DISP_LINES      = 128;

    // DMA-out bytes per visible line; one byte is requested per machine cycle.
    localparam int DMA_BYTES = 8;

    typedef enum logic [1:0] {
        SC_FETCH = 2'b00,
        SC_EXEC  = 2'b01,
        SC_DMA   = 2'b10,
        SC_INT   = 2'b11
    } sc_e;

    localparam logic [2:0] IO_DISP = 3'd1;

    typedef struct packed {
        logic [8:0] line;
        logic [3:0] mc;
        logic       disp_on;
        logic       line_act;
    } status_t;

    // Inclusive range test on a line number.
    function automatic logic in_window(input logic [8:0] v,
                                       input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/cdp1861_if.sv
// cdp1861_if: CPU-side bus between the CPU core and the Pixie.
//   cycle_en : one-CLOCK pulse per machine cycle (TPA aligned)
//   SC       : CPU state code
//   io_n     : CPU N lines, io_inp / io_out : IO strobes
//   data_in  : DMA byte from memory
//   INT_N, EFX_N, DMAO_N : active-low requests/flags back to the CPU
// Handshake: a DMA byte is accepted on a cycle_en where SC is DMA while
// DMAO_N is already low; the CPU owns every signal except the three flags.
interface cdp1861_if;
    logic       cycle_en;
    logic [1:0] SC;
    logic [2:0] io_n;
    logic       io_inp;
    logic       io_out;
    logic [7:0] data_in;
    logic       INT_N;
    logic       EFX_N;
    logic       DMAO_N;

    modport master (
        output cycle_en, SC, io_n, io_inp, io_out, data_in,
        input  INT_N, EFX_N, DMAO_N
    );

    modport slave (
        input  cycle_en, SC, io_n, io_inp, io_out, data_in,
        output INT_N, EFX_N, DMAO_N
    );
endinterface

// File: rtl/pixie_shifter.sv
// pixie_shifter: 8-bit load/shift register for one DMA byte.
//   CLOCK, RESET : system clock, async active-high reset
//   load         : capture data this CLOCK
//   data         : byte to serialise
//   pixel        : serial video, MSB first, registered
//   DE           : high for exactly the 8 CLOCKs a byte is on pixel
// The MSB is registered straight onto pixel at the load edge, so the
// following 7 CLOCKs only need the remaining 7 bits. A load arriving as
// the last bit is shown restarts the byte with no gap.
module pixie_shifter (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       load,
    input  logic [7:0] data,
    output logic       pixel,
    output logic       DE
);

    logic [6:0] sreg;
    logic [2:0] left;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            sreg  <= '0;
            left  <= '0;
            pixel <= 1'b0;
            DE    <= 1'b0;
        end else if (load) begin
            pixel <= data[7];
            sreg  <= data[6:0];
            left  <= 3'd7;
            DE    <= 1'b1;
        end else if (left != 3'd0) begin
            pixel <= sreg[6];
            sreg  <= {sreg[5:0], 1'b0};
            left  <= left - 3'd1;
            DE    <= 1'b1;
        end else begin
            pixel <= 1'b0;
            DE    <= 1'b0;
        end
    end

endmodule

// File: rtl/cdp1861.sv
// cdp1861: Pixie video display controller.
//   CLOCK, RESET : system clock (8 per machine cycle), async active-high reset
//   bus          : CPU-side bus (slave modport of cdp1861_if)
//   pixel, DE    : serial video and its valid strobe
//   HSYNC_N      : low for the last two machine cycles of each line
//   VSYNC_N      : low for lines 0..3
//   dbg          : line / machine-cycle counters and display flags
// Every flag is computed from the position (line, mc) of the machine cycle
// that carries cycle_en and registered on that edge; the counters then step
// to the next position.
module cdp1861
    import cdp1861_pkg::*;
#(
    parameter int CYCLES_PER_LINE = DEF_CYCLES_PER_LINE,
    parameter int LINES           = DEF_LINES,
    parameter int FIRST_LINE      = DEF_FIRST_LINE,
    parameter int DISP_LINES      = DEF_DISP_LINES
) (
    input  logic      CLOCK,
    input  logic      RESET,
    cdp1861_if.slave  bus,
    output logic      pixel,
    output logic      HSYNC_N,
    output logic      VSYNC_N,
    output logic      DE,
    output status_t   dbg
);

    localparam logic [3:0] MC_LAST   = 4'(CYCLES_PER_LINE - 1);
    localparam logic [3:0] MC_HS     = 4'(CYCLES_PER_LINE - 2);
    localparam logic [3:0] MC_DMA_HI = 4'(DMA_BYTES);
    localparam logic [8:0] LINE_LAST = 9'(LINES - 1);
    localparam logic [8:0] VIS_LO    = 9'(FIRST_LINE);
    localparam logic [8:0] VIS_HI    = 9'(FIRST_LINE + DISP_LINES - 1);
    localparam logic [8:0] INT_LO    = 9'(FIRST_LINE - 2);
    localparam logic [8:0] EF_TOP_LO = 9'(FIRST_LINE - 4);
    localparam logic [8:0] EF_BOT_LO = 9'(FIRST_LINE + DISP_LINES - 4);
    localparam logic [8:0] VS_HI     = 9'd3;

    logic [3:0] mc;
    logic [8:0] line;
    logic       disp_on;
    logic       line_act;
    logic       int_ack;
    logic       int_n_q;
    logic       efx_n_q;
    logic       dmao_n_q;

    logic act_now;
    logic visible;
    logic int_win;
    logic ack_now;
    logic disp_next;
    logic dma_load;

    always_comb begin
        // line_act is resampled at mc 0, so a line's activity is decided
        // once and a mid-line display change cannot cut it short.
        act_now   = (mc == 4'd0) ? disp_on : line_act;
        visible   = act_now && in_window(line, VIS_LO, VIS_HI);
        int_win   = in_window(line, INT_LO, VIS_LO - 9'd1);
        ack_now   = int_ack || (bus.SC == SC_INT);
        disp_next = disp_on;
        if (bus.io_n == IO_DISP) begin
            if (bus.io_out)
                disp_next = 1'b0;          // off wins over a same-cycle on
            else if (bus.io_inp)
                disp_next = 1'b1;
        end
        // DMAO_N is the value the CPU saw when it chose to do this DMA cycle.
        dma_load  = bus.cycle_en && (bus.SC == SC_DMA) && !dmao_n_q;
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mc       <= '0;
            line     <= '0;
            disp_on  <= 1'b0;
            line_act <= 1'b0;
            int_ack  <= 1'b0;
            int_n_q  <= 1'b1;
            efx_n_q  <= 1'b1;
            dmao_n_q <= 1'b1;
            HSYNC_N  <= 1'b1;
            VSYNC_N  <= 1'b1;
        end else if (bus.cycle_en) begin
            VSYNC_N  <= !(line <= VS_HI);
            HSYNC_N  <= !(mc >= MC_HS);
            dmao_n_q <= !(visible && (mc >= 4'd1) && (mc <= MC_DMA_HI));
            // The acknowledge only lives inside the two interrupt lines, so
            // it is forgotten by the next frame.
            int_ack  <= int_win && ack_now;
            int_n_q  <= !(disp_on && int_win && !ack_now);
            efx_n_q  <= !(disp_on && (in_window(line, EF_TOP_LO, VIS_LO - 9'd1) ||
                                      in_window(line, EF_BOT_LO, VIS_HI)));
            disp_on  <= disp_next;
            line_act <= act_now;
            if (mc == MC_LAST) begin
                mc   <= '0;
                line <= (line == LINE_LAST) ? 9'd0 : line + 9'd1;
            end else begin
                mc <= mc + 4'd1;
            end
        end
    end

    assign bus.INT_N  = int_n_q;
    assign bus.EFX_N  = efx_n_q;
    assign bus.DMAO_N = dmao_n_q;

    assign dbg.line     = line;
    assign dbg.mc       = mc;
    assign dbg.disp_on  = disp_on;
    assign dbg.line_act = line_act;

    pixie_shifter u_shift (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .load  (dma_load),
        .data  (bus.data_in),
        .pixel (pixel),
        .DE    (DE)
    );

endmodule

// File: tb/tb_cdp1861.sv
// tb_cdp1861: bench for the Pixie controller. The bench acts as the CPU,
// keeps a frame-position model of what every output should be, and checks
// the DUT each machine cycle and each CLOCK of pixel data.
module tb_cdp1861;
    import cdp1861_pkg::*;

    localparam int CPL = DEF_CYCLES_PER_LINE;
    localparam int NL  = DEF_LINES;
    localparam int FL  = DEF_FIRST_LINE;
    localparam int DL  = DEF_DISP_LINES;

    logic    CLOCK = 1'b0;
    logic    RESET;
    logic    pixel, HSYNC_N, VSYNC_N, DE;
    status_t dbg;

    cdp1861_if bus();

    cdp1861 dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .bus     (bus),
        .pixel   (pixel),
        .HSYNC_N (HSYNC_N),
        .VSYNC_N (VSYNC_N),
        .DE      (DE),
        .dbg     (dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 CLOCK = ~CLOCK;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model ----------------
    int   m_line, m_mc;
    bit   m_disp, m_act, m_ack;
    logic e_int, e_efx, e_dmao, e_hs, e_vs;
    logic [1:0] exp_q[$];          // {DE, pixel} expected per CLOCK

    // observations of the DUT, used by the directed scenarios
    int   n_dmao_lo, n_de, n_int_lo, n_efx_lo, n_vs_lo;
    bit   efx_lo[NL];
    bit   efx_hi[NL];
    bit   log_pix;
    logic pix_log[$];

    task automatic model_reset();
        m_line = 0; m_mc = 0;
        m_disp = 0; m_act = 0; m_ack = 0;
        e_int = 1; e_efx = 1; e_dmao = 1; e_hs = 1; e_vs = 1;
        exp_q.delete();
    endtask

    task automatic bus_idle();
        bus.cycle_en = 0; bus.SC = SC_FETCH; bus.io_n = 3'd0;
        bus.io_inp = 0; bus.io_out = 0; bus.data_in = 8'd0;
    endtask

    // ---------------- driver + scoreboard ----------------
    // One machine cycle: cycle_en on the first CLOCK, then seven more.
    task automatic mcycle(input logic [1:0] sc, input logic inp, input logic outp,
                          input logic [2:0] n, input logic [7:0] d);
        bit act, vis, win, ld;
        int ln, cm;
        logic [1:0] ex;
        status_t ed;
        @(negedge CLOCK);
        bus.cycle_en = 1; bus.SC = sc; bus.io_n = n;
        bus.io_inp = inp; bus.io_out = outp; bus.data_in = d;
        ln = m_line; cm = m_mc;
        act = (m_mc == 0) ? m_disp : m_act;
        vis = act && (m_line >= FL) && (m_line < FL + DL);
        ld  = (sc == SC_DMA) && (e_dmao == 1'b0);
        e_vs   = !(m_line < 4);
        e_hs   = !(m_mc >= CPL - 2);
        e_dmao = !(vis && m_mc >= 1 && m_mc <= 8);
        win    = (m_line == FL - 2) || (m_line == FL - 1);
        m_ack  = win && (m_ack || sc == SC_INT);
        e_int  = !(m_disp && win && !m_ack);
        e_efx  = !(m_disp && ((m_line >= FL - 4 && m_line < FL) ||
                              (m_line >= FL + DL - 4 && m_line < FL + DL)));
        if (n == 3'd1 && outp) m_disp = 0;
        else if (n == 3'd1 && inp) m_disp = 1;
        m_act = act;
        m_mc++;
        if (m_mc == CPL) begin m_mc = 0; m_line = (m_line + 1) % NL; end
        for (int k = 7; k >= 0; k--) exp_q.push_back(ld ? {1'b1, d[k]} : 2'b00);
        for (int c = 0; c < 8; c++) begin
            @(posedge CLOCK); #1;
            if (c == 0) begin
                bus.cycle_en = 0; bus.io_inp = 0; bus.io_out = 0;
                total++; if (bus.INT_N !== e_int) begin bad++;
                    $display("FAIL int_n line=%0d mc=%0d got=%b exp=%b", ln, cm, bus.INT_N, e_int); end
                total++; if (bus.EFX_N !== e_efx) begin bad++;
                    $display("FAIL efx_n line=%0d mc=%0d got=%b exp=%b", ln, cm, bus.EFX_N, e_efx); end
                total++; if (bus.DMAO_N !== e_dmao) begin bad++;
                    $display("FAIL dmao_n line=%0d mc=%0d got=%b exp=%b", ln, cm, bus.DMAO_N, e_dmao); end
                total++; if (HSYNC_N !== e_hs) begin bad++;
                    $display("FAIL hsync_n line=%0d mc=%0d got=%b exp=%b", ln, cm, HSYNC_N, e_hs); end
                total++; if (VSYNC_N !== e_vs) begin bad++;
                    $display("FAIL vsync_n line=%0d mc=%0d got=%b exp=%b", ln, cm, VSYNC_N, e_vs); end
                ed.line = 9'(m_line); ed.mc = 4'(m_mc); ed.disp_on = m_disp; ed.line_act = m_act;
                total++; if (dbg !== ed) begin bad++;
                    $display("FAIL status line=%0d mc=%0d got=%h exp=%h", ln, cm, dbg, ed); end
                if (bus.DMAO_N === 1'b0) n_dmao_lo++;
                if (bus.INT_N === 1'b0) n_int_lo++;
                if (VSYNC_N === 1'b0) n_vs_lo++;
                if (bus.EFX_N === 1'b0) begin n_efx_lo++; efx_lo[ln] = 1; end
                else efx_hi[ln] = 1;
            end
            ex = exp_q.pop_front();
            total++; if ({DE, pixel} !== ex) begin bad++;
                $display("FAIL video line=%0d mc=%0d clk=%0d got de/pix=%b%b exp=%b", ln, cm, c, DE, pixel, ex); end
            if (DE === 1'b1) begin
                n_de++;
                if (log_pix) pix_log.push_back(pixel);
            end
        end
    endtask

    // Random CPU traffic: answer DMA requests, otherwise fetch/execute,
    // with stray DMA states and IO strobes on ports other than the display.
    task automatic rand_cycle();
        logic [1:0] sc;
        logic [2:0] n;
        n = 3'($urandom_range(2, 7));
        if ($urandom_range(0, 3) == 0) n = 3'd0;
        if (!e_dmao) sc = SC_DMA;
        else if ($urandom_range(0, 15) == 0) sc = SC_DMA;
        else sc = ($urandom_range(0, 1) != 0) ? SC_EXEC : SC_FETCH;
        mcycle(sc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n, 8'($urandom));
    endtask

    task automatic run_to(input int l, input int mc);
        int guard = 0;
        while (!(m_line == l && m_mc == mc) && guard < 4000) begin
            rand_cycle();
            guard++;
        end
        total++;
        if (guard >= 4000) begin bad++;
            $display("FAIL run_to target=%0d/%0d got=%0d/%0d", l, mc, m_line, m_mc); end
    endtask

    task automatic do_reset();
        bus_idle();
        RESET = 1;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 0;
        model_reset();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus_idle();
        RESET = 1;
        repeat (3) @(posedge CLOCK);
        #1;
        total++; if ({bus.INT_N, bus.EFX_N, bus.DMAO_N, HSYNC_N, VSYNC_N} !== 5'b11111) begin bad++;
            $display("FAIL reset_flags got=%b exp=11111", {bus.INT_N, bus.EFX_N, bus.DMAO_N, HSYNC_N, VSYNC_N}); end
        total++; if ({DE, pixel} !== 2'b00) begin bad++;
            $display("FAIL reset_video got=%b%b exp=00", DE, pixel); end
        total++; if (dbg !== '0) begin bad++;
            $display("FAIL reset_status got=%h exp=0", dbg); end
        @(negedge CLOCK);
        RESET = 0;
        model_reset();
    endtask

    task automatic test_display_off();
        n_dmao_lo = 0; n_int_lo = 0; n_efx_lo = 0; n_vs_lo = 0;
        for (int i = 0; i < CPL * NL; i++) rand_cycle();
        total++; if (n_dmao_lo != 0) begin bad++; $display("FAIL off_dmao got=%0d exp=0", n_dmao_lo); end
        total++; if (n_int_lo != 0)  begin bad++; $display("FAIL off_int got=%0d exp=0", n_int_lo); end
        total++; if (n_efx_lo != 0)  begin bad++; $display("FAIL off_efx got=%0d exp=0", n_efx_lo); end
        total++; if (n_vs_lo != 4 * CPL) begin bad++; $display("FAIL off_vsync got=%0d exp=%0d", n_vs_lo, 4 * CPL); end
        total++; if (dbg.line !== 9'd0 || dbg.mc !== 4'd0) begin bad++;
            $display("FAIL frame_wrap got=%0d/%0d exp=0/0", dbg.line, dbg.mc); end
    endtask

    task automatic test_int();
        for (int i = 0; i < NL; i++) begin efx_lo[i] = 0; efx_hi[i] = 0; end
        mcycle(SC_EXEC, 1'b1, 1'b0, 3'd1, 8'd0);            // display on at line 0
        run_to(FL - 2, 0);
        mcycle(SC_FETCH, 1'b0, 1'b0, 3'd0, 8'd0);
        total++; if (bus.INT_N !== 1'b0) begin bad++; $display("FAIL int_assert got=%b exp=0", bus.INT_N); end
        run_to(FL - 2, 5);
        mcycle(SC_INT, 1'b0, 1'b0, 3'd0, 8'd0);
        total++; if (bus.INT_N !== 1'b1) begin bad++; $display("FAIL int_ack got=%b exp=1", bus.INT_N); end
        n_int_lo = 0;
        run_to(FL, 0);
        total++; if (n_int_lo != 0) begin bad++; $display("FAIL int_after_ack got=%0d exp=0", n_int_lo); end
    endtask

    task automatic test_display();
        logic [7:0]  tbl [3];
        logic [15:0] ref_bits;
        int bi;
        tbl[0] = 8'hA5; tbl[1] = 8'hFF; tbl[2] = 8'h00;
        ref_bits = 16'hA5FF;
        n_dmao_lo = 0; n_de = 0; pix_log.delete(); log_pix = 1; bi = 0;
        for (int mc = 0; mc < CPL; mc++) begin
            if (!e_dmao) begin
                mcycle(SC_DMA, 1'b0, 1'b0, 3'd0, (bi < 3) ? tbl[bi] : 8'($urandom));
                bi++;
            end else begin
                mcycle(SC_EXEC, 1'b0, 1'b0, 3'd0, 8'($urandom));
            end
        end
        log_pix = 0;
        total++; if (n_dmao_lo != 8) begin bad++; $display("FAIL line80_dmao got=%0d exp=8", n_dmao_lo); end
        total++; if (n_de != 64) begin bad++; $display("FAIL line80_de got=%0d exp=64", n_de); end
        total++;
        if (pix_log.size() < 16) begin bad++;
            $display("FAIL line80_pix_count got=%0d exp>=16", pix_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (pix_log[i] !== ref_bits[15 - i]) begin bad++;
                    $display("FAIL line80_pix bit=%0d got=%b exp=%b", i, pix_log[i], ref_bits[15 - i]);
                    break;
                end
            end
        end
    endtask

    task automatic test_disp_toggle();
        run_to(100, 0);
        n_dmao_lo = 0;
        run_to(100, 5);
        mcycle(SC_EXEC, 1'b1, 1'b1, 3'd1, 8'd0);
        total++; if (dbg.disp_on !== 1'b0) begin bad++; $display("FAIL toggle_disp got=%b exp=0", dbg.disp_on); end
        run_to(101, 0);
        total++; if (n_dmao_lo != 8) begin bad++; $display("FAIL line100_dmao got=%0d exp=8", n_dmao_lo); end
        n_dmao_lo = 0;
        run_to(102, 0);
        total++; if (n_dmao_lo != 0) begin bad++; $display("FAIL line101_dmao got=%0d exp=0", n_dmao_lo); end
        mcycle(SC_EXEC, 1'b1, 1'b0, 3'd1, 8'd0);            // back on for the bottom edge
        run_to(FL + DL + 1, 0);
    endtask

    task automatic test_efx();
        total++; if (efx_lo[FL - 5]) begin bad++; $display("FAIL efx_line%0d got=low exp=high", FL - 5); end
        for (int l = FL - 4; l < FL; l++) begin
            total++; if (efx_hi[l] || !efx_lo[l]) begin bad++; $display("FAIL efx_line%0d got=high exp=low", l); end
        end
        total++; if (efx_lo[FL]) begin bad++; $display("FAIL efx_line%0d got=low exp=high", FL); end
        for (int l = FL + DL - 4; l < FL + DL; l++) begin
            total++; if (efx_hi[l] || !efx_lo[l]) begin bad++; $display("FAIL efx_line%0d got=high exp=low", l); end
        end
        total++; if (efx_lo[FL + DL]) begin bad++; $display("FAIL efx_line%0d got=low exp=high", FL + DL); end
    endtask

    task automatic test_reset_mid_shift();
        do_reset();
        mcycle(SC_EXEC, 1'b1, 1'b0, 3'd1, 8'd0);
        run_to(FL, 2);
        @(negedge CLOCK);
        bus.cycle_en = 1; bus.SC = SC_DMA; bus.data_in = 8'hF0;
        @(posedge CLOCK); #1;
        bus.cycle_en = 0;
        total++; if ({DE, pixel} !== 2'b11) begin bad++; $display("FAIL f0_msb got=%b%b exp=11", DE, pixel); end
        repeat (3) @(posedge CLOCK);
        #1;
        total++; if ({DE, pixel} !== 2'b11) begin bad++; $display("FAIL f0_bit4 got=%b%b exp=11", DE, pixel); end
        #2 RESET = 1;
        #1;
        total++; if ({DE, pixel} !== 2'b00) begin bad++; $display("FAIL rst_video got=%b%b exp=00", DE, pixel); end
        total++; if ({bus.INT_N, bus.EFX_N, bus.DMAO_N, HSYNC_N, VSYNC_N} !== 5'b11111) begin bad++;
            $display("FAIL rst_flags got=%b exp=11111", {bus.INT_N, bus.EFX_N, bus.DMAO_N, HSYNC_N, VSYNC_N}); end
        total++; if (dbg !== '0) begin bad++; $display("FAIL rst_status got=%h exp=0", dbg); end
        bus_idle();
        repeat (2) @(negedge CLOCK);
        RESET = 0;
        model_reset();
        for (int c = 0; c < 8; c++) begin
            @(posedge CLOCK); #1;
            total++; if ({DE, pixel} !== 2'b00) begin bad++;
                $display("FAIL no_partial clk=%0d got=%b%b exp=00", c, DE, pixel); end
        end
        mcycle(SC_FETCH, 1'b0, 1'b0, 3'd0, 8'd0);
        total++; if (VSYNC_N !== 1'b0 || dbg.line !== 9'd0) begin bad++;
            $display("FAIL restart got vs=%b line=%0d exp vs=0 line=0", VSYNC_N, dbg.line); end
        for (int i = 0; i < 20; i++) rand_cycle();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        log_pix = 0;
        model_reset();
        test_reset();
        test_display_off();
        test_int();
        test_display();
        test_disp_toggle();
        test_efx();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cdp1861.md
# cdp1861

Pixie video display controller: the peripheral end of the CPU's DMA-out, interrupt and EF flag interface in the Studio II core. It counts machine cycles and lines, requests DMA-out of 8 bytes per visible line, and raises INT before the frame and EF1 around the frame edges. It consumes the CPU's DMA bytes and serialises them into a 64-pixel monochrome line with sync and blank outputs for the video scaler.

## Interface
- CYCLES_PER_LINE, 14: machine cycles per scan line.
- LINES, 262: lines per frame.
- FIRST_LINE, 80: first visible line.
- DISP_LINES, 128: visible lines per frame.
- CLOCK  in  1  system clock; 8 CLOCKs per CPU machine cycle.
- RESET  in  1  asynchronous, active-high reset.
- cycle_en  in  1  one-CLOCK pulse per machine cycle, aligned to TPA.
- SC  in  2  CPU state code; 2'b10 = DMA, 2'b11 = interrupt.
- io_n  in  3  CPU N lines.
- io_inp  in  1  CPU input strobe.
- io_out  in  1  CPU output strobe.
- data_in  in  8  DMA byte from memory (CPU ram_q).
- INT_N  out  1  interrupt request, active low.
- EFX_N  out  1  frame-edge flag to EF1, active low.
- DMAO_N  out  1  DMA-out request, active low.
- pixel  out  1  serial video, 1 = lit.
- HSYNC_N  out  1  horizontal sync, active low.
- VSYNC_N  out  1  vertical sync, active low.
- DE  out  1  high while pixel is valid.

## Operation
- Counters: mc counts 0..CYCLES_PER_LINE-1 and line counts 0..LINES-1. Both advance only on cycle_en. mc wraps to 0 and increments line. line wraps from 261 to 0.
- Display enable: disp_on is set by io_inp with io_n==1 on cycle_en. It is cleared by io_out with io_n==1 on cycle_en. If both occur in the same cycle, clear wins.
- line_act samples disp_on at mc==0 of each line. A mid-line change never truncates a line.
- Visible line: FIRST_LINE <= line < FIRST_LINE+DISP_LINES and line_act = 1.
- DMAO_N is low for mc 1..8 of visible lines and high otherwise.
- INT_N is low on lines FIRST_LINE-2 and FIRST_LINE-1 when disp_on = 1. It releases on the first cycle_en with SC==2'b11, or at the end of line FIRST_LINE-1, whichever comes first.
- EFX_N is low on lines FIRST_LINE-4..FIRST_LINE-1 and on the last 4 visible lines, gated by disp_on.
- HSYNC_N is low for mc 12..13. VSYNC_N is low for lines 0..3.
- DMA capture: on cycle_en with SC==2'b10 and DMAO_N low, data_in is loaded into the shift register. The byte is then shifted out MSB first, one bit per CLOCK, for 8 CLOCKs. DE is high for exactly those 8 CLOCKs.
- A DMA cycle while DMAO_N is high is ignored.
- DE and pixel are 0 outside shifting.

## Timing
- All outputs are registered. Flag and sync outputs update on the CLOCK carrying cycle_en.
- Reset values: INT_N=1, EFX_N=1, DMAO_N=1, HSYNC_N=1, VSYNC_N=1, pixel=0, DE=0. mc, line, disp_on and line_act are all 0.
- After reset, the first cycle_en lands at line 0, mc 0. VSYNC_N goes low on that CLOCK.
- Pixel latency: the MSB of a byte appears on pixel one CLOCK after the capturing cycle_en. Bit 0 appears on the 8th CLOCK.
- The next cycle_en reloads the register with no gap.
- Reset asserted mid-line or mid-shift clears everything immediately. No partial byte is emitted after release.
- Frame length is CYCLES_PER_LINE*LINES*8 = 29344 CLOCKs.

## Structure
- Package cdp1861_pkg holds the SC code constants (SC_FETCH, SC_EXEC, SC_DMA, SC_INT) and the IO port number for display on/off (3'd1).
- Package cdp1861_pkg also holds the default line and cycle constants.
- Sub-module pixie_shifter contains the 8-bit load/shift register, the bit counter, and the DE/pixel generation.
- The timing counters and flag logic stay in cdp1861.

## Test plan
- Display off after reset, run 1 frame -> DMAO_N, INT_N and EFX_N stay high. VSYNC_N is low for 4*14 cycle_en periods per frame.
- io_inp with io_n=1, then run to line 78 -> INT_N low at line 78 mc 0. It releases on the first SC=2'b11 cycle.
- Display on, line 80 -> DMAO_N low for mc 1..8. Feed bytes 8'hA5, 8'hFF, 8'h00, … with SC=2'b10. pixel sequence begins 1,0,1,0,0,1,0,1, then eight 1s. DE pulses total 64 CLOCKs.
- EFX_N check -> low on lines 76..79 and 204..207, high on line 75, 80 and 208.
- Display on and off strobes in the same cycle mid-line 100 -> disp_on = 0. Line 100 still completes 8 DMA requests. Line 101 has none.
- RESET pulse during the shift of byte 8'hF0 at bit 3 -> pixel = 0 and DE = 0 immediately. All outputs are at reset values. The counter restarts at line 0 after release.
